// File: rtl/dcache_tag_scoreboard_if.sv
// Request/response handshake bundle between the core memory unit, the tag
// scoreboard and the HPDC ports. Signal suffixes are seen from the scoreboard.
interface dcache_tag_scoreboard_if #(
    parameter int unsigned TAG_W = 7
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [TAG_W-1:0] req_tag_i;
    logic             cache_req_valid_o;
    logic             cache_req_ready_i;
    logic             cache_rsp_valid_i;
    logic [TAG_W-1:0] cache_rsp_tag_i;

    // Scoreboard side
    modport slave (
        input  req_valid_i,
        input  req_tag_i,
        input  cache_req_ready_i,
        input  cache_rsp_valid_i,
        input  cache_rsp_tag_i,
        output req_ready_o,
        output cache_req_valid_o
    );

    // Environment side (core + HPDC)
    modport master (
        output req_valid_i,
        output req_tag_i,
        output cache_req_ready_i,
        output cache_rsp_valid_i,
        output cache_rsp_tag_i,
        input  req_ready_o,
        input  cache_req_valid_o
    );
endinterface

// File: rtl/dcache_tag_scoreboard.sv
// Outstanding-tag scoreboard between the core memory unit and the HPDC.
// Blocks reissue of pending tags, caps the outstanding count at MAX_INFLIGHT
// and sequences fences (drain in-flight requests and the write buffer).
// Optional macro DCACHE_SCB_FATAL_EN: simulation-only $fatal on duplicate
// sends or spurious responses; synthesised logic is the same either way.
module dcache_tag_scoreboard #(
    parameter  int unsigned TAG_W        = 7,
    parameter  int unsigned MAX_INFLIGHT = 8,
    localparam int unsigned CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    dcache_tag_scoreboard_if.slave  bus,
    input  logic                    wbuf_empty_i,
    input  logic                    fence_i,
    output logic                    fence_done_o,
    output logic [CNT_W-1:0]        inflight_o,
    output logic                    err_dup_o,
    output logic                    err_spurious_o
);

    localparam int unsigned NumTags = 2 ** TAG_W;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_d;
    logic [NumTags-1:0] r_table;
    logic [NumTags-1:0] w_table_d;
    logic [CNT_W-1:0]   r_inflight;
    logic [CNT_W-1:0]   w_inflight_d;
    logic               r_err_dup;
    logic               r_err_spur;

    logic w_at_limit;
    logic w_block;
    logic w_send;
    logic w_rcv;
    logic w_spur;
    logic w_dup;
    logic w_fence_done;

    // Request gating: combinational from request inputs and fence only
    always_comb begin
        w_at_limit = (r_inflight == CNT_W'(MAX_INFLIGHT));
        w_block    = r_table[bus.req_tag_i] | w_at_limit | (r_state != StRun) | fence_i;
        w_send     = bus.req_valid_i & ~w_block & bus.cache_req_ready_i;
        w_dup      = w_send & r_table[bus.req_tag_i];
        w_rcv      = bus.cache_rsp_valid_i & r_table[bus.cache_rsp_tag_i];
        w_spur     = bus.cache_rsp_valid_i & ~r_table[bus.cache_rsp_tag_i];
    end

    assign bus.cache_req_valid_o = bus.req_valid_i & ~w_block;
    assign bus.req_ready_o       = bus.cache_req_ready_i & ~w_block;

    // Next table and counter; a send and a receive cannot hit the same tag
    always_comb begin
        w_table_d = r_table;
        if (w_rcv) begin
            w_table_d[bus.cache_rsp_tag_i] = 1'b0;
        end
        if (w_send) begin
            w_table_d[bus.req_tag_i] = 1'b1;
        end
        w_inflight_d = r_inflight + CNT_W'(w_send) - CNT_W'(w_rcv);
    end

    // Tag table and outstanding counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_table    <= '0;
            r_inflight <= '0;
        end else begin
            r_table    <= w_table_d;
            r_inflight <= w_inflight_d;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_dup  <= 1'b0;
            r_err_spur <= 1'b0;
        end else begin
            if (w_dup) begin
                r_err_dup <= 1'b1;
            end
            if (w_spur) begin
                r_err_spur <= 1'b1;
            end
`ifdef DCACHE_SCB_FATAL_EN
            if (w_dup) begin
                $fatal(1, "dcache_tag_scoreboard: duplicate send tag 0x%0h at %0t",
                       bus.req_tag_i, $time);
            end
            if (w_spur) begin
                $fatal(1, "dcache_tag_scoreboard: spurious response tag 0x%0h at %0t",
                       bus.cache_rsp_tag_i, $time);
            end
`else
            // Errors are reported through the sticky flags only
`endif
        end
    end

    // Fence FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Fence FSM next state; fence_i only matters in RUN
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StRun: begin
                if (fence_i) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if ((r_inflight == '0) && wbuf_empty_i) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StRun;
            end
            default: begin
                w_state_d = StRun;
            end
        endcase
    end

    // Fence FSM outputs
    always_comb begin
        w_fence_done = 1'b0;
        if (r_state == StDone) begin
            w_fence_done = 1'b1;
        end
    end

    assign fence_done_o   = w_fence_done;
    assign inflight_o     = r_inflight;
    assign err_dup_o      = r_err_dup;
    assign err_spurious_o = r_err_spur;

endmodule

// File: tb/tb_dcache_tag_scoreboard.sv
// Directed bench for dcache_tag_scoreboard: a vector table for the basic
// handshake/fence behaviour plus hand sequences for limit, draining fence
// and asynchronous reset. A second instance with MAX_INFLIGHT=4 covers the limit.
module tb_dcache_tag_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [6:0] req_tag = '0;
    logic       cache_ready = 1'b0;
    logic       rsp_valid = 1'b0;
    logic [6:0] rsp_tag = '0;
    logic       wbuf_empty = 1'b1;
    logic       fence = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dcache_tag_scoreboard_if #(.TAG_W(7)) bus8 ();
    dcache_tag_scoreboard_if #(.TAG_W(7)) bus4 ();

    assign bus8.req_valid_i       = req_valid;
    assign bus8.req_tag_i         = req_tag;
    assign bus8.cache_req_ready_i = cache_ready;
    assign bus8.cache_rsp_valid_i = rsp_valid;
    assign bus8.cache_rsp_tag_i   = rsp_tag;
    assign bus4.req_valid_i       = req_valid;
    assign bus4.req_tag_i         = req_tag;
    assign bus4.cache_req_ready_i = cache_ready;
    assign bus4.cache_rsp_valid_i = rsp_valid;
    assign bus4.cache_rsp_tag_i   = rsp_tag;

    logic       done8, dup8, spur8;
    logic [3:0] cnt8;
    logic       done4, dup4, spur4;
    logic [2:0] cnt4;

    dcache_tag_scoreboard #(.TAG_W(7), .MAX_INFLIGHT(8)) u_dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus8),
        .wbuf_empty_i   (wbuf_empty),
        .fence_i        (fence),
        .fence_done_o   (done8),
        .inflight_o     (cnt8),
        .err_dup_o      (dup8),
        .err_spurious_o (spur8)
    );

    dcache_tag_scoreboard #(.TAG_W(7), .MAX_INFLIGHT(4)) u_dut4 (
        .clk_i          (clk),
        .rst_i          (rst),
        .bus            (bus4),
        .wbuf_empty_i   (wbuf_empty),
        .fence_i        (fence),
        .fence_done_o   (done4),
        .inflight_o     (cnt4),
        .err_dup_o      (dup4),
        .err_spurious_o (spur4)
    );

    typedef struct packed {
        logic       rv;
        logic [6:0] tag;
        logic       crdy;
        logic       sv;
        logic [6:0] stag;
        logic       wb;
        logic       fen;
        logic       e_rdy;
        logic       e_cv;
        logic [3:0] e_cnt;
        logic       e_done;
        logic       e_spur;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic [6:0] tag, input logic crdy,
                         input logic sv, input logic [6:0] stag, input logic wb,
                         input logic fen);
        req_valid   = rv;
        req_tag     = tag;
        cache_ready = crdy;
        rsp_valid   = sv;
        rsp_tag     = stag;
        wbuf_empty  = wb;
        fence       = fen;
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send8(input logic [6:0] tag, input logic wb);
        drive(1'b1, tag, 1'b1, 1'b0, 7'h00, wb, 1'b0);
        #1;
        check($sformatf("send_%0h.rdy", tag), int'(bus8.req_ready_o), 1);
        step();
    endtask

    initial begin
        //            rv    tag    crdy  sv    stag   wb    fen   rdy   cv    cnt   done  spur
        vecs[0]  = '{1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 7'h05, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 7'h05, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 7'h05, 1'b1, 1'b1, 7'h05, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 7'h05, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 7'h01, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 7'h09, 1'b1, 1'b1, 7'h01, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 7'h09, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 7'h01, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 7'h00, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 7'h00, 1'b1, 1'b1, 7'h05, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 7'h00, 1'b1, 1'b1, 7'h09, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 7'h02, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 7'h02, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 7'h02, 1'b1, 1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 7'h02, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 7'h00, 1'b0, 1'b1, 7'h02, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};

        // Reset state while reset is held
        #2;
        check("rst.cnt", int'(cnt8), 0);
        check("rst.done", int'(done8), 0);
        check("rst.dup", int'(dup8), 0);
        check("rst.spur", int'(spur8), 0);
        do_reset();

        // Vector table: dup tag, simultaneous send/rsp, spurious, empty fence
        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].rv, vecs[i].tag, vecs[i].crdy, vecs[i].sv, vecs[i].stag,
                  vecs[i].wb, vecs[i].fen);
            #1;
            check($sformatf("vec%0d.rdy", i), int'(bus8.req_ready_o), int'(vecs[i].e_rdy));
            check($sformatf("vec%0d.cv", i), int'(bus8.cache_req_valid_o), int'(vecs[i].e_cv));
            check($sformatf("vec%0d.cnt", i), int'(cnt8), int'(vecs[i].e_cnt));
            check($sformatf("vec%0d.done", i), int'(done8), int'(vecs[i].e_done));
            check($sformatf("vec%0d.dup", i), int'(dup8), 0);
            check($sformatf("vec%0d.spur", i), int'(spur8), int'(vecs[i].e_spur));
            step();
        end

        // Limit on the MAX_INFLIGHT=4 instance
        do_reset();
        for (int t = 1; t <= 4; t++) begin
            drive(1'b1, 7'(t), 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
            #1;
            check($sformatf("lim.send%0d", t), int'(bus4.req_ready_o), 1);
            step();
        end
        drive(1'b1, 7'h05, 1'b1, 1'b1, 7'h02, 1'b1, 1'b0);
        #1;
        check("lim.cnt4", int'(cnt4), 4);
        check("lim.blk_rdy", int'(bus4.req_ready_o), 0);
        check("lim.blk_cv", int'(bus4.cache_req_valid_o), 0);
        step();
        drive(1'b1, 7'h05, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        #1;
        check("lim.cnt3", int'(cnt4), 3);
        check("lim.unblk_rdy", int'(bus4.req_ready_o), 1);
        check("lim.unblk_cv", int'(bus4.cache_req_valid_o), 1);
        step();
        drive(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        #1;
        check("lim.cnt_after", int'(cnt4), 4);
        check("lim.dup4", int'(dup4), 0);
        check("lim.spur4", int'(spur4), 0);
        check("lim.done4", int'(done4), 0);

        // Fence with three outstanding requests and a busy write buffer
        do_reset();
        send8(7'h10, 1'b0);
        send8(7'h11, 1'b0);
        send8(7'h12, 1'b0);
        drive(1'b1, 7'h20, 1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
        #1;
        check("fen.cnt3", int'(cnt8), 3);
        check("fen.c0_rdy", int'(bus8.req_ready_o), 0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 7'h20, 1'b1, 1'b1, 7'(8'h10 + i), 1'b0, 1'b0);
            #1;
            check($sformatf("fen.drain%0d_rdy", i), int'(bus8.req_ready_o), 0);
            check($sformatf("fen.drain%0d_cv", i), int'(bus8.cache_req_valid_o), 0);
            check($sformatf("fen.drain%0d_done", i), int'(done8), 0);
            step();
        end
        drive(1'b1, 7'h20, 1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
        #1;
        check("fen.wb_busy_cnt", int'(cnt8), 0);
        check("fen.wb_busy_rdy", int'(bus8.req_ready_o), 0);
        check("fen.wb_busy_done", int'(done8), 0);
        step();
        drive(1'b1, 7'h20, 1'b1, 1'b0, 7'h00, 1'b1, 1'b0);
        #1;
        check("fen.k_rdy", int'(bus8.req_ready_o), 0);
        check("fen.k_done", int'(done8), 0);
        step();
        #1;
        check("fen.k1_done", int'(done8), 1);
        check("fen.k1_rdy", int'(bus8.req_ready_o), 0);
        step();
        #1;
        check("fen.k2_done", int'(done8), 0);
        check("fen.k2_rdy", int'(bus8.req_ready_o), 1);
        check("fen.k2_cv", int'(bus8.cache_req_valid_o), 1);
        step();
        drive(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        #1;
        check("fen.after_cnt", int'(cnt8), 1);

        // Asynchronous reset with five tags pending
        do_reset();
        for (int t = 0; t < 5; t++) begin
            send8(7'(8'h30 + t), 1'b1);
        end
        drive(1'b0, 7'h00, 1'b0, 1'b1, 7'h7F, 1'b1, 1'b0);
        step();
        drive(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        #1;
        check("ar.cnt5", int'(cnt8), 5);
        check("ar.spur_pre", int'(spur8), 1);
        rst = 1'b1;
        #1;
        check("ar.cnt0", int'(cnt8), 0);
        check("ar.spur0", int'(spur8), 0);
        check("ar.dup0", int'(dup8), 0);
        check("ar.done0", int'(done8), 0);
        step();
        rst = 1'b0;
        drive(1'b0, 7'h00, 1'b0, 1'b1, 7'h30, 1'b1, 1'b0);
        step();
        drive(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        #1;
        check("ar.stale_spur", int'(spur8), 1);
        check("ar.stale_cnt", int'(cnt8), 0);
        for (int t = 0; t < 5; t++) begin
            send8(7'(8'h30 + t), 1'b1);
        end
        drive(1'b0, 7'h00, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0);
        #1;
        check("ar.reissue_cnt", int'(cnt8), 5);
        check("ar.dup_end", int'(dup8), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dcache_tag_scoreboard.md
# dcache_tag_scoreboard

Parametrised request-tracking scoreboard placed between the core's memory unit and the HPDC request/response ports. It gates the valid/ready handshake so that no tag is reissued while still outstanding and the number of outstanding requests never exceeds a configurable limit. It also provides a fence sequencer that drains all in-flight requests and the write buffer before acknowledging. This is the generalised successor of the fixed 128-tag, single-limit tag table in the dcache interface.

## Interface
- TAG_W, 7, tag width; the table has 2**TAG_W entries
- MAX_INFLIGHT, 8, maximum outstanding requests; legal range 1..2**TAG_W
- CNT_W, $clog2(MAX_INFLIGHT+1), derived; must not be overridden
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  core request accepted this cycle (when high together with req_valid_i)
- req_tag_i  in  TAG_W  tag of the core request
- cache_req_valid_o  out  1  request valid towards HPDC
- cache_req_ready_i  in  1  HPDC ready
- cache_rsp_valid_i  in  1  HPDC response valid; always accepted
- cache_rsp_tag_i  in  TAG_W  tag of the response
- wbuf_empty_i  in  1  HPDC write buffer empty
- fence_i  in  1  fence request, level-sampled in RUN
- fence_done_o  out  1  one-cycle pulse on fence completion
- inflight_o  out  CNT_W  current outstanding count (registered)
- err_dup_o  out  1  sticky: send with a pending tag
- err_spurious_o  out  1  sticky: response for an idle tag

## Operation
- Table: one bit per tag (0 IDLE, 1 PENDING).
- block = table[req_tag_i] | (inflight_o == MAX_INFLIGHT) | (state != RUN) | fence_i.
- cache_req_valid_o = req_valid_i & ~block.
- req_ready_o = cache_req_ready_i & ~block.
- send = cache_req_valid_o & cache_req_ready_i. On send, the table entry for req_tag_i is set to PENDING.
- rcv = cache_rsp_valid_i & table[cache_rsp_tag_i]. On rcv, the table entry for cache_rsp_tag_i is set to IDLE.
- inflight_o next value = inflight_o + send - rcv. When send and rcv occur in the same cycle, the count is unchanged. The counter saturates neither way; the block logic guarantees the range 0..MAX_INFLIGHT.
- Response for an IDLE tag: table and counter unchanged; err_spurious_o set.
- err_dup_o is set if send occurs with the table bit set. This is unreachable by construction and exists as a safety check.
- Error flags are cleared only by reset.
- FSM states:
  - RUN: fence_i=1 goes to DRAIN.
  - DRAIN: (inflight_o==0 & wbuf_empty_i) goes to DONE; otherwise stays in DRAIN.
  - DONE: fence_done_o=1 for this cycle, then returns to RUN.
- fence_i is ignored outside RUN.
- Reset mid-operation: table cleared, counter 0, FSM to RUN. Responses arriving after reset for pre-reset tags are reported as spurious.

## Timing
- Reset values: table all IDLE, inflight_o=0, state RUN, fence_done_o=0, err_dup_o=0, err_spurious_o=0.
- The request path is combinational from req_valid_i, req_tag_i, cache_req_ready_i and fence_i to the outputs. There is no combinational path from cache_rsp_* to the request outputs.
- A tag freed by a response in cycle N can be reissued in cycle N+1 at the earliest.
- A tag sent in cycle N is blocked from cycle N+1.
- At the limit: a response in cycle N unblocks a new send in cycle N+1.
- Fence with an empty system and wbuf_empty_i=1: fence_i high in cycle 0, DRAIN in cycle 1, fence_done_o high in cycle 2. Requests are blocked in cycles 0–2.
- While in DRAIN, responses continue to be processed normally.

## Configuration
- DCACHE_SCB_FATAL_EN defined:
  - A simulation-only check in the sequential block prints the tag and $time, then calls $fatal, on any duplicate send or spurious response.
  - The sticky flags are still driven.
- DCACHE_SCB_FATAL_EN undefined: no simulation checks; only the sticky flags report these errors.
- Synthesised logic is identical in both cases.

## Test plan
- Duplicate tag: send tag 0x05 accepted, then req tag 0x05 with cache_req_ready_i=1 -> cache_req_valid_o=0 and req_ready_o=0 until response tag 0x05. Reissue is accepted on the following cycle.
- Limit: MAX_INFLIGHT=4, send tags 1,2,3,4 -> inflight_o=4; tag 5 blocked. Response tag 2 -> inflight_o=3 and tag 5 accepted the next cycle.
- Simultaneous send/response: with inflight_o=2, send tag 9 and respond tag 1 in the same cycle -> inflight_o stays 2, table[9]=PENDING, table[1]=IDLE.
- Spurious response: response tag 0x7F while idle -> err_spurious_o=1, inflight_o=0. With DCACHE_SCB_FATAL_EN defined, simulation terminates.
- Fence: 3 outstanding requests, wbuf_empty_i=0, fence_i pulse.
  - All requests stay blocked.
  - After the 3 responses plus wbuf_empty_i=1 in cycle K, fence_done_o is high in cycle K+1.
  - Requests are accepted again in cycle K+2.
- Reset mid-operation: assert rst_i with 5 tags pending -> outputs return to reset values immediately (asynchronous); all tags are issuable after reset is released.
